// File: rtl/cdf_pkg.sv
// Shared types and helpers for the CDF fetch stage.
package cdf_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_TAG_VALUE = 16'hAAAA;

    // Width able to hold every bin index plus the terminal count NUM_BINS.
    function automatic int bin_idx_w(input int num_bins);
        return $clog2(num_bins + 1);
    endfunction

endpackage

// File: rtl/cdf_fetch_stream_if.sv
// Memory read port and output bin stream of the CDF fetch stage.
interface cdf_fetch_stream_if #(
    parameter int ADDR_W = 16,
    parameter int BUS_W  = 128,
    parameter int DATA_W = 20
);
    logic              rd_en;
    logic [ADDR_W-1:0] ReadAddress;
    logic [BUS_W-1:0]  ReadBus;

    // A beat transfers on any cycle with out_valid && out_ready; once out_valid
    // rises it stays high, with out_data/out_addr/out_last held, until that transfer.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output rd_en, ReadAddress, out_valid, out_data, out_addr, out_last,
        input  ReadBus, out_ready
    );

    modport slave (
        input  rd_en, ReadAddress, out_valid, out_data, out_addr, out_last,
        output ReadBus, out_ready
    );
endinterface

// File: rtl/cdf_fetch_fifo.sv
// Two-entry fall-through FIFO: an empty FIFO presents the incoming word at once.
module cdf_fetch_fifo #(
    parameter int W = 37
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_empty;
    logic w_store;
    logic w_deq;

    assign w_empty = (r_count == 2'd0);
    // A word popped in the same cycle it arrives into an empty FIFO is never stored.
    assign w_store = push && !(w_empty && pop);
    assign w_deq   = pop && !w_empty;

    assign head_valid = !w_empty || push;
    assign head_data  = !w_empty ? r_mem[r_rd_ptr] : (push ? push_data : {W{1'b0}});
    assign count      = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_store) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq)   r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clock) begin
        if (w_store && !flush) r_mem[r_wr_ptr] <= push_data;
    end
endmodule

// File: rtl/cdf_fetch_stream.sv
// Fetch stage: reads NUM_BINS tagged histogram words and streams the bin counts out.
module cdf_fetch_stream
    import cdf_pkg::*;
#(
    parameter int NUM_BINS = 256,
    parameter int ADDR_W   = 16,
    parameter int BUS_W    = 128,
    parameter int DATA_W   = 20,
    parameter int TAG_W    = 16,
    parameter logic [TAG_W-1:0] TAG_VALUE = DEFAULT_TAG_VALUE,
    parameter int ERR_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  tag_err_cnt,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_fifo_count,
    cdf_fetch_stream_if.master bus
);
    localparam int BIN_W = bin_idx_w(NUM_BINS);
    localparam int PAY_W = DATA_W + ADDR_W + 1;
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(NUM_BINS - 1);
    localparam logic [BIN_W-1:0] ALL_IDX  = BIN_W'(NUM_BINS);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [BIN_W-1:0]  r_issued;
    logic              r_ret_valid;
    logic [ADDR_W-1:0] r_ret_addr;
    logic              r_ret_last;
    logic [ERR_W-1:0]  r_err;

    logic              w_issue;
    logic              w_accept;
    logic [TAG_W-1:0]  w_tag;
    logic              w_tag_ok;
    logic [DATA_W-1:0] w_bin;
    logic [PAY_W-1:0]  w_push_data;
    logic              w_head_valid;
    logic [PAY_W-1:0]  w_head;
    logic              w_pop;
    logic              w_last_hs;
    logic [1:0]        w_fifo_count;
    logic              w_unused_bus;

    assign w_tag        = bus.ReadBus[DATA_W+TAG_W-1:DATA_W];
    assign w_tag_ok     = (w_tag == TAG_VALUE);
    assign w_bin        = w_tag_ok ? bus.ReadBus[DATA_W-1:0] : {DATA_W{1'b0}};
    assign w_push_data  = {w_bin, r_ret_addr, r_ret_last};
    assign w_unused_bus = ^bus.ReadBus[BUS_W-1:DATA_W+TAG_W];

    assign w_accept = (r_state == S_IDLE) && start && !abort;
    // Credit of two: FIFO occupancy plus the word returning this cycle.
    assign w_issue  = (r_state == S_FETCH) && !abort && (r_issued != ALL_IDX) &&
                      (({1'b0, w_fifo_count} + {2'b00, r_ret_valid}) < 3'd2);
    assign w_pop     = w_head_valid && bus.out_ready;
    assign w_last_hs = w_pop && w_head[0];

    cdf_fetch_fifo #(.W(PAY_W)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (abort),
        .push       (r_ret_valid),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .head_valid (w_head_valid),
        .head_data  (w_head),
        .count      (w_fifo_count)
    );

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_FETCH;
                // The last beat can already hand off before FETCH sees the final issue.
                S_FETCH: if (w_last_hs) w_next = S_DONE;
                         else if (r_issued == ALL_IDX) w_next = S_DRAIN;
                S_DRAIN: if (w_last_hs) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_issued    <= '0;
            r_ret_valid <= 1'b0;
            r_ret_addr  <= '0;
            r_ret_last  <= 1'b0;
            r_err       <= '0;
        end else begin
            r_state <= w_next;
            if (abort) begin
                r_ret_valid <= 1'b0;
            end else begin
                r_ret_valid <= w_issue;
                if (w_issue) begin
                    r_ret_addr <= r_addr;
                    r_ret_last <= (r_issued == LAST_IDX);
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_issued   <= r_issued + BIN_W'(1);
                end
                if (r_ret_valid && !w_tag_ok && (r_err != {ERR_W{1'b1}}))
                    r_err <= r_err + ERR_W'(1);
                if (w_accept) begin
                    r_addr   <= base_addr;
                    r_issued <= '0;
                    r_err    <= '0;
                end
            end
        end
    end

    assign bus.rd_en       = w_issue;
    assign bus.ReadAddress = r_addr;
    assign bus.out_valid   = w_head_valid;
    assign bus.out_data    = w_head[PAY_W-1 -: DATA_W];
    assign bus.out_addr    = w_head[ADDR_W:1];
    assign bus.out_last    = w_head[0];

    assign busy           = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign tag_err_cnt    = r_err;
    assign dbg_state      = r_state;
    assign dbg_fifo_count = w_fifo_count;
endmodule

// File: tb/tb_cdf_fetch_stream.sv
// Self-checking bench for cdf_fetch_stream: nominal, tag errors, backpressure, wrap, abort, reset.
module tb_cdf_fetch_stream;
    import cdf_pkg::*;

    localparam int AW = 16;
    localparam int BW = 128;
    localparam int DW = 20;
    localparam int TW = 16;
    localparam int EW = 8;
    localparam int NA = 256;
    localparam int NB = 8;
    localparam int PW = DW + AW + 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    cdf_fetch_stream_if #(.ADDR_W(AW), .BUS_W(BW), .DATA_W(DW)) ifa ();
    cdf_fetch_stream_if #(.ADDR_W(AW), .BUS_W(BW), .DATA_W(DW)) ifb ();

    logic          start_a = 1'b0, abort_a = 1'b0;
    logic [AW-1:0] base_a = '0;
    logic          busy_a, done_a;
    logic [EW-1:0] err_a;
    logic [1:0]    st_a, fc_a;

    logic          start_b = 1'b0, abort_b = 1'b0;
    logic [AW-1:0] base_b = '0;
    logic          busy_b, done_b;
    logic [EW-1:0] err_b;
    logic [1:0]    st_b, fc_b;

    cdf_fetch_stream #(.NUM_BINS(NA), .ADDR_W(AW), .BUS_W(BW), .DATA_W(DW), .TAG_W(TW), .ERR_W(EW)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .base_addr(base_a),
        .busy(busy_a), .done(done_a), .tag_err_cnt(err_a), .dbg_state(st_a),
        .dbg_fifo_count(fc_a), .bus(ifa.master)
    );

    cdf_fetch_stream #(.NUM_BINS(NB), .ADDR_W(AW), .BUS_W(BW), .DATA_W(DW), .TAG_W(TW), .ERR_W(EW)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .base_addr(base_b),
        .busy(busy_b), .done(done_b), .tag_err_cnt(err_b), .dbg_state(st_b),
        .dbg_fifo_count(fc_b), .bus(ifb.master)
    );

    // ---------------- memory model ----------------
    bit bad_en = 1'b0;

    function automatic bit is_bad(input logic [AW-1:0] a);
        return bad_en && (a == 16'h0105 || a == 16'h0110);
    endfunction

    function automatic logic [BW-1:0] mk_word(input logic [AW-1:0] a);
        logic [TW-1:0] t;
        t = 16'hAAAA;
        if (bad_en && a == 16'h0105) t = 16'h5555;
        if (bad_en && a == 16'h0110) t = 16'h0000;
        return {{(BW-DW-TW){1'b1}}, t, {(DW-8){1'b0}}, a[7:0]};
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        return is_bad(a) ? {DW{1'b0}} : {{(DW-8){1'b0}}, a[7:0]};
    endfunction

    always @(posedge clock) begin
        ifa.ReadBus <= ifa.rd_en ? mk_word(ifa.ReadAddress) : {4{$urandom}};
        ifb.ReadBus <= ifb.rd_en ? mk_word(ifb.ReadAddress) : {4{$urandom}};
    end

    // ---------------- driver: downstream ready ----------------
    int pct_a = 100;
    initial begin
        ifa.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            ifa.out_ready = ($urandom_range(0, 99) < pct_a);
        end
    end

    // ---------------- scoreboard / checker ----------------
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_b[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    int start_cyc_a = 0, first_rd_a = -1, first_ov_a = -1, last_cyc_a = 0;
    int done_cyc_a = 0, done_cnt_a = 0, beats_a = 0;
    int stall_viol = 0, rd_full_viol = 0, max_fc = 0;
    bit pv = 1'b0, pr = 1'b0;
    logic [PW-1:0] pp, exp_w;

    always @(negedge clock) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (ifa.out_valid && ifa.out_ready) begin
                beats_a++;
                if (ifa.out_last) last_cyc_a = cyc;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {ifa.out_data, ifa.out_addr, ifa.out_last}, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("beat_a", {ifa.out_data, ifa.out_addr, ifa.out_last}, exp_w);
                end
            end
            if (pv && !pr && busy_a &&
                (!ifa.out_valid || {ifa.out_data, ifa.out_addr, ifa.out_last} != pp))
                stall_viol++;
            if (ifa.rd_en && fc_a == 2'd2) rd_full_viol++;
            if (int'(fc_a) > max_fc) max_fc = int'(fc_a);
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (start_a && st_a == 2'd0 && !abort_a) start_cyc_a = cyc;
            if (ifa.rd_en && first_rd_a < 0) first_rd_a = cyc;
            if (ifa.out_valid && first_ov_a < 0) first_ov_a = cyc;
            pv = ifa.out_valid;
            pr = ifa.out_ready;
            pp = {ifa.out_data, ifa.out_addr, ifa.out_last};
        end
    end

    task automatic push_run(input logic [AW-1:0] base, output int n_err);
        logic [AW-1:0] a;
        n_err = 0;
        for (int i = 0; i < NA; i++) begin
            a = base + AW'(i);
            exp_q.push_back({exp_data(a), a, (i == NA - 1)});
            if (is_bad(a)) n_err++;
        end
    endtask

    task automatic pulse_start_a(input logic [AW-1:0] base);
        @(posedge clock); #2;
        start_a = 1'b1;
        base_a  = base;
        @(posedge clock); #2;
        start_a = 1'b0;
        base_a  = 16'h7777;
    endtask

    task automatic run_a(input logic [AW-1:0] base, input int pct, input bit bad, input bit poke);
        int n_err;
        bad_en = bad;
        pct_a  = pct;
        push_run(base, n_err);
        first_rd_a = -1; first_ov_a = -1; done_cnt_a = 0; beats_a = 0;
        pulse_start_a(base);
        for (int k = 0; k < 20000 && done_cnt_a == 0; k++) begin
            @(posedge clock); #2;
            start_a = (poke && k == 30);
        end
        start_a = 1'b0;
        check("done_seen", done_cnt_a, 1);
        repeat (3) begin @(posedge clock); #2; end
        check("done_once", done_cnt_a, 1);
        check("done_after_last", done_cyc_a - last_cyc_a, 1);
        check("beat_count", beats_a, NA);
        check("queue_empty", exp_q.size(), 0);
        check("tag_err_cnt", err_a, n_err);
        check("busy_low", busy_a, 0);
        check("state_idle", st_a, 0);
        if (pct == 100) begin
            check("lat_rd_en", first_rd_a - start_cyc_a, 1);
            check("lat_out_valid", first_ov_a - start_cyc_a, 2);
            check("throughput", last_cyc_a - first_ov_a, NA - 1);
        end
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int saved;
        logic [AW-1:0] a;
        ifb.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clock);
        #2;
        check("rst_ctrl_a", {busy_a, done_a, err_a, ifa.rd_en, ifa.out_valid, ifa.out_last, st_a, fc_a}, 0);
        check("rst_data_a", {ifa.ReadAddress, ifa.out_data, ifa.out_addr}, 0);
        check("rst_ctrl_b", {busy_b, done_b, err_b, ifb.rd_en, ifb.out_valid, st_b}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // nominal, tag mismatch, backpressure with start pulse mid-run
        run_a(16'h0100, 100, 1'b0, 1'b0);
        run_a(16'h0100, 100, 1'b1, 1'b0);
        run_a(16'h0100, 30, 1'b0, 1'b1);

        // address wrap on the 8-bin instance
        bad_en = 1'b0;
        for (int i = 0; i < NB; i++) begin
            a = 16'hFFFC + AW'(i);
            exp_b.push_back({exp_data(a), a, (i == NB - 1)});
        end
        @(posedge clock); #2;
        start_b = 1'b1; base_b = 16'hFFFC;
        @(posedge clock); #2;
        start_b = 1'b0; base_b = 16'h0000;
        saved = 0;
        for (int k = 0; k < 200 && saved == 0; k++) begin
            @(negedge clock);
            if (ifb.out_valid && ifb.out_ready) begin
                if (exp_b.size() == 0)
                    check("wrap_unexpected", {ifb.out_data, ifb.out_addr, ifb.out_last}, 64'd0);
                else
                    check("wrap_beat", {ifb.out_data, ifb.out_addr, ifb.out_last}, exp_b.pop_front());
            end
            if (done_b) saved = 1;
        end
        check("wrap_done", saved, 1);
        check("wrap_queue_empty", exp_b.size(), 0);
        check("wrap_tag_err", err_b, 0);

        // abort at beat 10 with a same-cycle start
        pct_a = 100;
        push_run(16'h0200, saved);
        beats_a = 0; done_cnt_a = 0;
        pulse_start_a(16'h0200);
        for (int k = 0; k < 1000 && beats_a < 10; k++) begin
            @(posedge clock); #2;
        end
        check("abort_reached_beat10", beats_a >= 10, 1);
        abort_a = 1'b1; start_a = 1'b1; base_a = 16'h0500;
        @(posedge clock); #2;
        abort_a = 1'b0; start_a = 1'b0;
        exp_q.delete();
        check("abort_busy", busy_a, 0);
        check("abort_valid", ifa.out_valid, 0);
        check("abort_state", st_a, 0);
        saved = beats_a;
        repeat (5) begin @(posedge clock); #2; end
        check("abort_no_done", done_cnt_a, 0);
        check("abort_no_beats", beats_a, saved);
        run_a(16'h0300, 100, 1'b0, 1'b0);

        // async reset mid-FETCH
        bad_en = 1'b1;
        pct_a  = 30;
        push_run(16'h0100, saved);
        beats_a = 0;
        pulse_start_a(16'h0100);
        for (int k = 0; k < 2000 && beats_a < 8; k++) begin
            @(posedge clock); #2;
        end
        check("pre_reset_fetch", st_a, 1);
        check("pre_reset_err", err_a, 1);
        reset = 1'b1;
        #1;
        check("midrst_ctrl", {busy_a, done_a, err_a, ifa.rd_en, ifa.out_valid, ifa.out_last, st_a, fc_a}, 0);
        check("midrst_data", {ifa.ReadAddress, ifa.out_data, ifa.out_addr}, 0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        saved = beats_a;
        repeat (10) begin @(posedge clock); #2; end
        check("post_reset_idle", {busy_a, st_a, ifa.out_valid}, 0);
        check("post_reset_no_beats", beats_a, saved);
        run_a(16'h0100, 30, 1'b1, 1'b1);

        // invariants accumulated over the whole run
        check("stall_stable", stall_viol, 0);
        check("rd_en_while_full", rd_full_viol, 0);
        check("fifo_max_le2", max_fc <= 2, 1);
        check("fifo_reached_2", max_fc, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cdf_fetch_stream.md
Name: cdf_fetch_stream

Overview:
- Parametrised fetch stage at the head of the CDF pipeline.
- On a start pulse it reads NUM_BINS consecutive histogram words from the read memory, beginning at a latched base address.
- Each word's tag field is checked; the bin count is extracted, or zeroed when the tag mismatches.
- Each bin is delivered downstream through a valid/ready stream with its source address and a last flag, with full backpressure support.

Parameters:
- NUM_BINS, 256, number of bins fetched per run (>=2).
- ADDR_W, 16, read/store address width.
- BUS_W, 128, read data bus width.
- DATA_W, 20, bin count field width, located at ReadBus[DATA_W-1:0].
- TAG_W, 16, tag field width, located at ReadBus[DATA_W+TAG_W-1:DATA_W].
- TAG_VALUE, 16'hAAAA, tag required for a valid word.
- ERR_W, 8, width of the saturating tag-error counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; ignored unless idle.
- abort  in  1  synchronous flush back to idle.
- base_addr  in  ADDR_W  first read address, sampled when start is accepted.
- ReadBus  in  BUS_W  memory read data, valid exactly 1 cycle after rd_en.
- rd_en  out  1  memory read strobe.
- ReadAddress  out  ADDR_W  memory read address.
- out_valid  out  1  output data valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  bin count, or 0 on tag mismatch.
- out_addr  out  ADDR_W  address that produced out_data.
- out_last  out  1  marks the final bin of a run.
- busy  out  1  high from start acceptance through the final handshake.
- done  out  1  one-cycle pulse after the final handshake.
- tag_err_cnt  out  ERR_W  saturating mismatch count for the current run.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; internal issue counter 0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on start. On this transition:
  - latch base_addr into the address register;
  - clear issue count and tag_err_cnt;
  - assert busy.
- FETCH, read issue:
  - issue (rd_en=1, ReadAddress=current address) when issued < NUM_BINS and fifo_count + inflight < 2;
  - on each issue, address += 1 with mod 2^ADDR_W wrap (wrap is legal, not an error) and issued += 1.
- Read return:
  - the word arriving 1 cycle after an issue is pushed into a 2-entry FIFO as {data, addr, last};
  - last = (bin index == NUM_BINS-1).
- Extraction:
  - tag == TAG_VALUE -> data = count field;
  - otherwise data = 0 and tag_err_cnt += 1, saturating at all-ones.
- Output handshake:
  - out_* driven from the FIFO head; out_valid = FIFO not empty;
  - pop on out_valid & out_ready;
  - out_valid must never drop without a handshake while busy;
  - out_data, out_addr and out_last stay stable while stalled.
- Throughput: 1 bin/cycle when out_ready is held high.
- Latency: start accepted (cycle 0) -> first rd_en in cycle 1 -> first out_valid in cycle 2.
- FETCH -> DRAIN when issued == NUM_BINS.
- DRAIN -> DONE on the handshake of the out_last beat.
- DONE: done=1 for 1 cycle, busy drops, then IDLE. tag_err_cnt holds its value until the next start.
- start while not IDLE: ignored, with no effect on the current run.
- abort in any state:
  - next cycle: IDLE, FIFO flushed, out_valid=0, busy=0, done not pulsed;
  - in-flight read data returning the cycle after abort is discarded;
  - abort takes priority over a same-cycle start.
- Reset mid-run: immediate return to the reset state; no partial-run outputs afterwards.
- The same-cycle FIFO push and pop is supported; count is unchanged.

Decomposition:
- Package cdf_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, DONE);
  - default TAG_VALUE;
  - a function for the bin-index width, clog2(NUM_BINS+1).
- Sub-module cdf_fetch_fifo: 2-entry FIFO parametrised by payload width, with push/pop/count/flush.

Test Plan:
- Nominal run: NUM_BINS=256, base_addr=0x0100, all tags 0xAAAA, counts = addr[7:0], out_ready=1.
  -> 256 beats with out_addr 0x0100..0x01FF and matching counts, out_last on 0x01FF, done 1 cycle after, tag_err_cnt=0.
- Tag mismatch: tag at 0x0105 = 0x5555 and at 0x0110 = 0x0000.
  -> out_data=0 on those two beats, tag_err_cnt=2, all other beats unaffected.
- Backpressure: out_ready random at 30% high.
  -> no lost or duplicated beats, payload stable while stalled, fifo_count never exceeds 2, rd_en pauses while full.
- Wrap: NUM_BINS=8, base_addr=0xFFFC.
  -> out_addr sequence FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003, with last on 0003.
- Abort at beat 10, with start asserted in the same cycle.
  -> next cycle busy=0 and out_valid=0, no done pulse; a following start runs cleanly from the new base_addr.
- Async reset mid-FETCH.
  -> all outputs 0 immediately; start ignored while busy, checked by pulsing start during a run, which must leave the beat count at NUM_BINS.
